// File: rtl/id_exe_if.sv
// ID->EXE pipeline register bus.
// Carries the stage-control inputs (freeze, flush), the decoded ID-stage
// fields (in_*), and their registered EXE-stage copies (out_*).
//   master : the ID/hazard side. It drives freeze, flush and in_*, and reads out_*.
//   slave  : the pipeline register. It reads freeze, flush and in_*, and drives out_*.
// Handshake: there is no back-pressure. in_valid qualifies in_* on every
// rising edge unless freeze or flush is high. out_valid qualifies out_* for the
// whole following cycle. A slot with out_valid=0 carries no side effects.
interface id_exe_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CMD_W      = 4
);
  logic                  freeze;
  logic                  flush;

  logic                  in_valid;
  logic [DATA_W-1:0]     in_pc;
  logic [DATA_W-1:0]     in_val_rn;
  logic [DATA_W-1:0]     in_val_rm;
  logic                  in_imm;
  logic [11:0]           in_shift_op;
  logic [23:0]           in_imm24;
  logic [CMD_W-1:0]      in_exe_cmd;
  logic [REG_ADDR_W-1:0] in_dest;
  logic [REG_ADDR_W-1:0] in_src1;
  logic [REG_ADDR_W-1:0] in_src2;
  logic                  in_wb_en;
  logic                  in_mem_r_en;
  logic                  in_mem_w_en;
  logic                  in_b;
  logic                  in_s;
  logic [3:0]            in_status;

  logic                  out_valid;
  logic [DATA_W-1:0]     out_pc;
  logic [DATA_W-1:0]     out_val_rn;
  logic [DATA_W-1:0]     out_val_rm;
  logic                  out_imm;
  logic [11:0]           out_shift_op;
  logic [23:0]           out_imm24;
  logic [CMD_W-1:0]      out_exe_cmd;
  logic [REG_ADDR_W-1:0] out_dest;
  logic [REG_ADDR_W-1:0] out_src1;
  logic [REG_ADDR_W-1:0] out_src2;
  logic                  out_wb_en;
  logic                  out_mem_r_en;
  logic                  out_mem_w_en;
  logic                  out_b;
  logic                  out_s;
  logic [3:0]            out_status;
  logic                  out_is_mem;

  modport master (
    output freeze, flush,
    output in_valid, in_pc, in_val_rn, in_val_rm, in_imm, in_shift_op, in_imm24,
           in_exe_cmd, in_dest, in_src1, in_src2, in_wb_en, in_mem_r_en,
           in_mem_w_en, in_b, in_s, in_status,
    input  out_valid, out_pc, out_val_rn, out_val_rm, out_imm, out_shift_op,
           out_imm24, out_exe_cmd, out_dest, out_src1, out_src2, out_wb_en,
           out_mem_r_en, out_mem_w_en, out_b, out_s, out_status, out_is_mem
  );

  modport slave (
    input  freeze, flush,
    input  in_valid, in_pc, in_val_rn, in_val_rm, in_imm, in_shift_op, in_imm24,
           in_exe_cmd, in_dest, in_src1, in_src2, in_wb_en, in_mem_r_en,
           in_mem_w_en, in_b, in_s, in_status,
    output out_valid, out_pc, out_val_rn, out_val_rm, out_imm, out_shift_op,
           out_imm24, out_exe_cmd, out_dest, out_src1, out_src2, out_wb_en,
           out_mem_r_en, out_mem_w_en, out_b, out_s, out_status, out_is_mem
  );
endinterface

// File: rtl/id_exe_reg.sv
// ID->EXE pipeline register.
// It captures the decoded operands and control bits once per cycle and holds
// them for the EXE stage. The latency is one cycle, and there is no
// combinational path from in_* to out_*.
// Update priority on each rising edge: rst > flush > freeze > load.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset. It clears every output.
//   bus : id_exe_if slave. It carries freeze, flush, in_* and the registered out_*.
module id_exe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CMD_W      = 4
) (
  input  logic     clk,
  input  logic     rst,
  id_exe_if.slave  bus
);

  logic                  valid_q;
  logic [DATA_W-1:0]     pc_q;
  logic [DATA_W-1:0]     val_rn_q;
  logic [DATA_W-1:0]     val_rm_q;
  logic                  imm_q;
  logic [11:0]           shift_op_q;
  logic [23:0]           imm24_q;
  logic [CMD_W-1:0]      exe_cmd_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [REG_ADDR_W-1:0] src1_q;
  logic [REG_ADDR_W-1:0] src2_q;
  logic                  wb_en_q;
  logic                  mem_r_en_q;
  logic                  mem_w_en_q;
  logic                  b_q;
  logic                  s_q;
  logic [3:0]            status_q;
  logic                  is_mem_q;

  // Side-effect bits are gated with in_valid so that a bubble can never write
  // back, touch memory, branch or update the flags.
  // A read-plus-write request degrades to a plain read (read wins).
  logic ld_wb_en, ld_mem_r_en, ld_mem_w_en, ld_b, ld_s;

  always_comb begin
    ld_wb_en    = bus.in_valid & bus.in_wb_en;
    ld_mem_r_en = bus.in_valid & bus.in_mem_r_en;
    ld_mem_w_en = bus.in_valid & bus.in_mem_w_en & ~bus.in_mem_r_en;
    ld_b        = bus.in_valid & bus.in_b;
    ld_s        = bus.in_valid & bus.in_s;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      val_rn_q   <= '0;
      val_rm_q   <= '0;
      imm_q      <= 1'b0;
      shift_op_q <= '0;
      imm24_q    <= '0;
      exe_cmd_q  <= '0;
      dest_q     <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      b_q        <= 1'b0;
      s_q        <= 1'b0;
      status_q   <= '0;
      is_mem_q   <= 1'b0;
    end else if (!bus.freeze) begin
      // A bubble still captures the data fields. Downstream ignores them
      // because out_valid is low.
      valid_q    <= bus.in_valid;
      pc_q       <= bus.in_pc;
      val_rn_q   <= bus.in_val_rn;
      val_rm_q   <= bus.in_val_rm;
      imm_q      <= bus.in_imm;
      shift_op_q <= bus.in_shift_op;
      imm24_q    <= bus.in_imm24;
      exe_cmd_q  <= bus.in_exe_cmd;
      dest_q     <= bus.in_dest;
      src1_q     <= bus.in_src1;
      src2_q     <= bus.in_src2;
      wb_en_q    <= ld_wb_en;
      mem_r_en_q <= ld_mem_r_en;
      mem_w_en_q <= ld_mem_w_en;
      b_q        <= ld_b;
      s_q        <= ld_s;
      status_q   <= bus.in_status;
      is_mem_q   <= ld_mem_r_en | ld_mem_w_en;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_val_rn   = val_rn_q;
  assign bus.out_val_rm   = val_rm_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_shift_op = shift_op_q;
  assign bus.out_imm24    = imm24_q;
  assign bus.out_exe_cmd  = exe_cmd_q;
  assign bus.out_dest     = dest_q;
  assign bus.out_src1     = src1_q;
  assign bus.out_src2     = src2_q;
  assign bus.out_wb_en    = wb_en_q;
  assign bus.out_mem_r_en = mem_r_en_q;
  assign bus.out_mem_w_en = mem_w_en_q;
  assign bus.out_b        = b_q;
  assign bus.out_s        = s_q;
  assign bus.out_status   = status_q;
  assign bus.out_is_mem   = is_mem_q;

  // Slot invariants.
  a_bubble_no_side_effects: assert property (@(posedge clk)
    !valid_q |-> !(wb_en_q | mem_r_en_q | mem_w_en_q | b_q | s_q | is_mem_q));
  a_is_mem_consistent: assert property (@(posedge clk)
    is_mem_q == (mem_r_en_q | mem_w_en_q));
  a_mem_rw_exclusive: assert property (@(posedge clk)
    !(mem_r_en_q && mem_w_en_q));

endmodule

// File: tb/tb_id_exe_reg.sv
module tb_id_exe_reg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int CMD_W      = 4;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     val_rn;
    logic [DATA_W-1:0]     val_rm;
    logic                  imm;
    logic [11:0]           shift_op;
    logic [23:0]           imm24;
    logic [CMD_W-1:0]      exe_cmd;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  b;
    logic                  s;
    logic [3:0]            status;
    logic                  is_mem;
  } slot_t;
  localparam int W = $bits(slot_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_exe_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CMD_W(CMD_W)) bus ();

  id_exe_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CMD_W(CMD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  string phase = "init";
  slot_t model = '0;

  function automatic slot_t get_out();
    slot_t g;
    g.valid    = bus.out_valid;
    g.pc       = bus.out_pc;
    g.val_rn   = bus.out_val_rn;
    g.val_rm   = bus.out_val_rm;
    g.imm      = bus.out_imm;
    g.shift_op = bus.out_shift_op;
    g.imm24    = bus.out_imm24;
    g.exe_cmd  = bus.out_exe_cmd;
    g.dest     = bus.out_dest;
    g.src1     = bus.out_src1;
    g.src2     = bus.out_src2;
    g.wb_en    = bus.out_wb_en;
    g.mem_r_en = bus.out_mem_r_en;
    g.mem_w_en = bus.out_mem_w_en;
    g.b        = bus.out_b;
    g.s        = bus.out_s;
    g.status   = bus.out_status;
    g.is_mem   = bus.out_is_mem;
    return g;
  endfunction

  // Reference model, evaluated at each rising edge from the inputs present
  // at that edge. The expected output for the next cycle goes into exp_q.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst || bus.flush) begin
      model = '0;
    end else if (!bus.freeze) begin
      model.valid    = bus.in_valid;
      model.pc       = bus.in_pc;
      model.val_rn   = bus.in_val_rn;
      model.val_rm   = bus.in_val_rm;
      model.imm      = bus.in_imm;
      model.shift_op = bus.in_shift_op;
      model.imm24    = bus.in_imm24;
      model.exe_cmd  = bus.in_exe_cmd;
      model.dest     = bus.in_dest;
      model.src1     = bus.in_src1;
      model.src2     = bus.in_src2;
      if (bus.in_valid) begin
        model.wb_en    = bus.in_wb_en;
        model.mem_r_en = bus.in_mem_r_en;
        model.mem_w_en = bus.in_mem_r_en ? 1'b0 : bus.in_mem_w_en;
        model.b        = bus.in_b;
        model.s        = bus.in_s;
      end else begin
        model.wb_en    = 1'b0;
        model.mem_r_en = 1'b0;
        model.mem_w_en = 1'b0;
        model.b        = 1'b0;
        model.s        = 1'b0;
      end
      model.status = bus.in_status;
      model.is_mem = model.mem_r_en | model.mem_w_en;
    end
    exp_q.push_back(model);
  end

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    slot_t g;
    slot_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = get_out();
      checks = checks + 1;
      if (g !== e) begin
        failures = failures + 1;
        $display("FAIL %s cycle=%0d outputs got=%h exp=%h", phase, cyc, g, e);
      end
      checks = checks + 1;
      if (!g.valid && (g.wb_en | g.mem_r_en | g.mem_w_en | g.b | g.s | g.is_mem)) begin
        failures = failures + 1;
        $display("FAIL %s bubble_ctrl cycle=%0d got=%h exp=0", phase, cyc,
                 {g.wb_en, g.mem_r_en, g.mem_w_en, g.b, g.s, g.is_mem});
      end
      checks = checks + 1;
      if (g.is_mem !== (g.mem_r_en | g.mem_w_en) || (g.mem_r_en && g.mem_w_en)) begin
        failures = failures + 1;
        $display("FAIL %s is_mem cycle=%0d got is_mem=%b r=%b w=%b exp is_mem=r|w, r&w=0",
                 phase, cyc, g.is_mem, g.mem_r_en, g.mem_w_en);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs(input logic valid);
    logic [31:0] r;
    bus.in_valid    = valid;
    bus.in_pc       = $urandom;
    bus.in_val_rn   = $urandom;
    bus.in_val_rm   = $urandom;
    r = $urandom;
    bus.in_imm      = r[0];
    bus.in_wb_en    = r[1];
    bus.in_mem_r_en = r[2];
    bus.in_mem_w_en = r[3];
    bus.in_b        = r[4];
    bus.in_s        = r[5];
    bus.in_status   = r[9:6];
    bus.in_exe_cmd  = r[13:10];
    bus.in_dest     = r[17:14];
    bus.in_src1     = r[21:18];
    bus.in_src2     = r[25:22];
    r = $urandom;
    bus.in_shift_op = r[11:0];
    bus.in_imm24    = $urandom_range(24'hFF_FFFF, 0);
  endtask

  task automatic all_ones();
    bus.freeze      = 1'b1;
    bus.flush       = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_pc       = '1;
    bus.in_val_rn   = '1;
    bus.in_val_rm   = '1;
    bus.in_imm      = 1'b1;
    bus.in_shift_op = '1;
    bus.in_imm24    = '1;
    bus.in_exe_cmd  = '1;
    bus.in_dest     = '1;
    bus.in_src1     = '1;
    bus.in_src2     = '1;
    bus.in_wb_en    = 1'b1;
    bus.in_mem_r_en = 1'b1;
    bus.in_mem_w_en = 1'b1;
    bus.in_b        = 1'b1;
    bus.in_s        = 1'b1;
    bus.in_status   = '1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    all_ones();

    phase = "reset";
    tick();
    tick();
    rst        = 1'b0;
    bus.freeze = 1'b0;
    bus.flush  = 1'b0;

    phase = "load_alu";
    rand_inputs(1'b1);
    bus.in_val_rm   = 32'h8000_0001;
    bus.in_imm      = 1'b0;
    bus.in_shift_op = 12'h0E3;
    bus.in_wb_en    = 1'b1;
    bus.in_mem_r_en = 1'b0;
    bus.in_mem_w_en = 1'b0;
    tick();

    phase = "load_ldr";
    rand_inputs(1'b1);
    bus.in_mem_r_en = 1'b1;
    bus.in_mem_w_en = 1'b0;
    bus.in_shift_op = 12'h004;
    tick();
    phase = "freeze_hold";
    bus.freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(1'($urandom_range(1, 0)));
      tick();
    end
    phase = "freeze_release";
    bus.freeze = 1'b0;
    rand_inputs(1'b1);
    tick();

    phase = "flush_over_freeze";
    rand_inputs(1'b1);
    bus.in_mem_r_en = 1'b0;
    bus.in_mem_w_en = 1'b1;
    tick();
    bus.flush  = 1'b1;
    bus.freeze = 1'b1;
    tick();
    bus.flush  = 1'b0;
    bus.freeze = 1'b0;

    phase = "bubble";
    rand_inputs(1'b0);
    bus.in_wb_en    = 1'b1;
    bus.in_mem_w_en = 1'b1;
    bus.in_b        = 1'b1;
    bus.in_val_rn   = 32'h0000_1234;
    tick();

    phase = "read_wins";
    rand_inputs(1'b1);
    bus.in_mem_r_en = 1'b1;
    bus.in_mem_w_en = 1'b1;
    tick();

    phase = "reset_mid_freeze";
    rand_inputs(1'b1);
    tick();
    bus.freeze = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.freeze = 1'b0;
    rand_inputs(1'b1);
    tick();

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(49, 0) == 0);
      bus.flush  = ($urandom_range(9, 0) == 0);
      bus.freeze = ($urandom_range(4, 0) == 0);
      rand_inputs(($urandom_range(3, 0) != 0));
      tick();
    end
    rst        = 1'b0;
    bus.flush  = 1'b0;
    bus.freeze = 1'b0;
    tick();
    tick();
    @(negedge clk);
    #1;

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
